pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline register. It replaces the fixed IFID/IDEX/EXMEM/MEMWB-style latches with one reusable stage.
- Data moves with a valid/ready handshake, so stalls propagate stage by stage and no global stall wire is needed.
- Optional 2-entry skid mode registers the upstream ready path.
- Adds synchronous flush with bubble injection, plus sticky protocol-error detection.
- Sits between any two processor stages. The control and data bundle is packed into one WIDTH-bit payload.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_buf_pipe_proto_chk.sv | 69 ++++++
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 tb/tb_pipe_stage_buf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage and its protocol checker.
package pipe_pkg;

  // The encoding doubles as the occupancy count: EMPTY=0, ONE=1, TWO=2.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  localparam int OCC_W = 2;

  // Entries held for a given state; the unencoded value reports zero.
  function automatic logic [OCC_W-1:0] state_occ(input logic [1:0] s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

  function automatic logic state_legal(input logic [1:0] s);
    return (s == ST_EMPTY) || (s == ST_ONE) || (s == ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_buf_pipe_proto_chk.sv
// Sticky protocol/state error detector for pipe_stage_buf.
// Watches the upstream handshake for withdrawn or altered offers and the
// stage state register for illegal values.
module pipe_proto_chk
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic [1:0]       state,
  output logic             err
);

  logic             prev_valid_q, prev_valid_d;
  logic             prev_ready_q, prev_ready_d;
  logic             prev_flush_q, prev_flush_d;
  logic [WIDTH-1:0] prev_data_q,  prev_data_d;
  logic             err_q,        err_d;

  logic stall_prev;
  logic withdrawn;
  logic altered;
  logic bad_state;
  logic skid_viol;

  // Compare this cycle's offer against the stalled offer of the last cycle.
  always_comb begin
    prev_valid_d = in_valid;
    prev_ready_d = in_ready;
    prev_flush_d = flush;
    prev_data_d  = in_data;

    // A flushed stall releases the upstream from holding its offer.
    stall_prev = prev_valid_q & ~prev_ready_q & ~prev_flush_q;
    withdrawn  = stall_prev & ~in_valid;
    // A still-asserted offer must keep its payload stable until accepted.
    altered    = stall_prev & in_valid & (in_data != prev_data_q);
    bad_state  = ~state_legal(state);
    skid_viol  = ~SKID & (state == ST_TWO);

    err_d = err_q | withdrawn | altered | bad_state | skid_viol;
  end

  // Previous-cycle handshake capture and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_flush_q <= 1'b0;
      prev_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_ready_q <= prev_ready_d;
      prev_flush_q <= prev_flush_d;
      prev_data_q  <= prev_data_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer,
// synchronous flush with bubble injection and sticky error reporting.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic             err
);

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] main_q,     main_d;
  logic [WIDTH-1:0] skid_q,     skid_d;
  logic             in_ready_q, in_ready_d;

  logic in_xfer;
  logic out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_occ(state_q);
  // Skid mode decouples in_ready from out_ready; otherwise it is a pass-through.
  assign in_ready  = SKID ? in_ready_q : (~out_valid | out_ready);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and datapath: head in main, overflow in skid, FIFO order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              state_d = ST_TWO;
              skid_d  = in_data;
            end
            2'b01: begin
              state_d = ST_EMPTY;
              main_d  = BUBBLE_VAL;
            end
            2'b11: main_d = in_data;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // State, payload registers and registered upstream ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_proto_chk #(
    .WIDTH (WIDTH),
    .SKID  (SKID)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .state    (state_q),
    .err      (err)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: one skid instance, one single-register
// instance, each checked against an ordered queue of accepted payloads.
module tb_pipe_stage_buf;

  localparam logic [63:0] BUB1 = 64'hB0B0_0000_0000_B0B0;
  localparam logic [63:0] BUB0 = 64'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        iv1 = 1'b0, or1 = 1'b0, fl1 = 1'b0;
  logic [63:0] id1 = '0;
  logic        ir1, ov1, err1;
  logic [63:0] od1;
  logic [1:0]  occ1;

  logic        iv0 = 1'b0, or0 = 1'b0, fl0 = 1'b0;
  logic [63:0] id0 = '0;
  logic        ir0, ov0, err0;
  logic [63:0] od0;
  logic [1:0]  occ0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(64), .SKID(1'b1), .BUBBLE_VAL(BUB1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
    .occupancy(occ1), .err(err1));

  pipe_stage_buf #(.WIDTH(64), .SKID(1'b0), .BUBBLE_VAL(BUB0)) u_flat (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
    .occupancy(occ0), .err(err0));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the reference is just an ordered list of accepted payloads.
  always begin
    @(negedge clk);
    #2;
    if (mon_on) begin
      check("s1_valid", ov1, q1.size() > 0);
      check("s1_data", od1, (q1.size() > 0) ? q1[0] : BUB1);
      check("s1_occ", occ1, q1.size());
      check("s1_in_ready", ir1, q1.size() < 2);
      if (q1.size() > 0 && or1) void'(q1.pop_front());
      if (fl1) q1.delete();

      check("s0_valid", ov0, q0.size() > 0);
      check("s0_data", od0, (q0.size() > 0) ? q0[0] : BUB0);
      check("s0_occ", occ0, q0.size());
      check("s0_in_ready", ir0, (q0.size() == 0) || or0);
      if (q0.size() > 0 && or0) void'(q0.pop_front());
      if (fl0) q0.delete();
    end
  end

  task automatic drive(input bit w, input bit v, input logic [63:0] d, input bit r, input bit f);
    if (w) begin iv1 = v; id1 = d; or1 = r; fl1 = f; end
    else   begin iv0 = v; id0 = d; or0 = r; fl0 = f; end
  endtask

  function automatic bit rdy(input bit w);
    return w ? ir1 : ir0;
  endfunction

  // One cycle of stimulus; an accepted, unflushed offer joins the expected queue.
  task automatic cyc(input bit w, input bit v, input logic [63:0] d, input bit r,
                     input bit f, output bit acc);
    @(negedge clk);
    drive(w, v, d, r, f);
    #3;
    acc = v && rdy(w);
    if (acc && !f) begin
      if (w) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  // mode 0: random ready/flush; 1: out_ready 1,0,1 pattern; 2: ready held high.
  task automatic run(input bit w, input int n, input int mode);
    bit pend = 1'b0;
    bit acc, v, r, f;
    logic [63:0] d = '0;
    v = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        v = (mode != 0) || ($urandom_range(0, 9) < 7);
        d = {$urandom, $urandom};
      end
      case (mode)
        0:       r = ($urandom_range(0, 2) != 0);
        1:       r = ((i % 3) != 1);
        default: r = 1'b1;
      endcase
      f = (mode == 0) && ($urandom_range(0, 19) == 0);
      cyc(w, v, d, r, f, acc);
      pend = v && !acc && !f;
    end
    // A closing flush releases any held offer without a protocol error.
    cyc(w, pend, d, 1'b1, 1'b1, acc);
    cyc(w, 1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    #2 rst = 1'b0;
    #10;
    check("rst_valid1", ov1, 0);  check("rst_data1", od1, BUB1);
    check("rst_occ1", occ1, 0);   check("rst_err1", err1, 0);
    check("rst_rdy1", ir1, 1);
    check("rst_valid0", ov0, 0);  check("rst_data0", od0, BUB0);
    check("rst_occ0", occ0, 0);   check("rst_err0", err0, 0);
    check("rst_rdy0", ir0, 1);
    @(negedge clk);
    rst = 1'b1;
    mon_on = 1'b1;

    // One-cycle latency and streaming at one per cycle.
    cyc(1, 1, 64'h1234, 1, 0, acc);
    check("lat_acc", acc, 1);
    cyc(1, 0, '0, 1, 0, acc);
    check("lat_valid", ov1, 1);
    check("lat_data", od1, 64'h1234);
    check("lat_occ", occ1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 64'd100 + 64'(i), 1, 0, acc);
      check("thru_acc", acc, 1);
    end
    cyc(1, 0, '0, 1, 0, acc);
    cyc(1, 0, '0, 1, 0, acc);

    // Skid fill to two, then drain in order.
    cyc(1, 1, 64'd5, 0, 0, acc);
    cyc(1, 1, 64'd6, 0, 0, acc);
    cyc(1, 0, '0, 0, 0, acc);
    check("fill_occ", occ1, 2);
    check("fill_rdy", ir1, 0);
    check("fill_head", od1, 64'd5);
    cyc(1, 0, '0, 1, 0, acc);
    cyc(1, 0, '0, 1, 0, acc);
    check("pop1_data", od1, 64'd6);
    check("pop1_rdy", ir1, 1);
    cyc(1, 0, '0, 1, 0, acc);
    check("pop2_valid", ov1, 0);
    check("pop2_bubble", od1, BUB1);

    // Flush discards a simultaneous input, in ONE and in TWO.
    cyc(1, 1, 64'd8, 0, 0, acc);
    cyc(1, 1, 64'd9, 0, 1, acc);
    cyc(1, 0, '0, 0, 0, acc);
    check("fl1_occ", occ1, 0);
    check("fl1_data", od1, BUB1);
    cyc(1, 1, 64'd21, 0, 0, acc);
    cyc(1, 1, 64'd22, 0, 0, acc);
    cyc(1, 1, 64'd7, 0, 1, acc);
    cyc(1, 0, '0, 0, 0, acc);
    check("fl2_occ", occ1, 0);
    check("fl2_valid", ov1, 0);
    check("fl2_data", od1, BUB1);
    check("fl2_rdy", ir1, 1);

    run(1, 300, 0);
    run(1, 60, 2);
    run(0, 300, 0);
    run(0, 40, 1);
    run(0, 40, 2);
    check("clean_err1", err1, 0);
    check("clean_err0", err0, 0);

    // Withdrawn offer sets a sticky error one cycle later.
    cyc(1, 1, 64'd31, 0, 0, acc);
    cyc(1, 1, 64'd32, 0, 0, acc);
    cyc(1, 1, 64'd33, 0, 0, acc);
    check("stall_acc", acc, 0);
    cyc(1, 0, '0, 0, 0, acc);
    check("err1_early", err1, 0);
    cyc(1, 0, '0, 0, 0, acc);
    check("err1_set", err1, 1);
    cyc(1, 0, '0, 0, 0, acc);
    check("err1_sticky", err1, 1);
    cyc(0, 1, 64'd41, 0, 0, acc);
    cyc(0, 1, 64'd42, 0, 0, acc);
    cyc(0, 0, '0, 0, 0, acc);
    cyc(0, 0, '0, 0, 0, acc);
    check("err0_set", err0, 1);

    // Asynchronous reset mid-stream while holding two entries.
    @(negedge clk);
    #3;
    rst = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    check("mrst_valid1", ov1, 0); check("mrst_data1", od1, BUB1);
    check("mrst_occ1", occ1, 0);  check("mrst_rdy1", ir1, 1);
    check("mrst_err1", err1, 0);
    check("mrst_valid0", ov0, 0); check("mrst_err0", err0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 1, 64'd55, 1, 0, acc);
    cyc(1, 0, '0, 1, 0, acc);
    check("post_rst_valid", ov1, 1);
    check("post_rst_data", od1, 64'd55);
    cyc(1, 0, '0, 1, 0, acc);
    cyc(0, 0, '0, 1, 0, acc);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
